// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and helpers for the SPI register-port slave:
//             frame FSM state encoding, command read-bit position and
//             sample/launch edge selection from CPOL/CPHA.
//  Revision : 1.0  initial release
// ============================================================================
package spi_pkg;

   // Frame FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_WR   = 2'd2,
      ST_RD   = 2'd3
   } frame_state_e;

   // Position of the read/write flag in the command word (its MSB)
   function automatic int cmd_rd_bit(input int data_w);
      return data_w - 1;
   endfunction

   // Data is sampled on the rising SCLK edge when CPOL equals CPHA,
   // otherwise on the falling edge; data is launched on the opposite edge.
   function automatic bit sample_on_rise(input bit cpol, input bit cpha);
      return (cpol == cpha);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-stage synchroniser for one asynchronous input with
//             optional registered rise/fall pulses.
//  Ports    : clk, rst_n   - system clock, async active-low reset
//             din          - asynchronous input
//             dout         - synchronised level (STAGES clk latency)
//             rise, fall   - one-cycle edge pulses (STAGES+1 clk latency),
//                            tied low when EDGE_EN = 0
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
   parameter int STAGES  = 2,
   parameter bit RST_VAL = 1'b0,
   parameter bit EDGE_EN = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
   end

   // Reset to the line's idle level so no edge is reported after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q, rise_q, fall_q;
         logic rise_d, fall_d;

         always_comb begin
            rise_d = dout & ~prev_q;
            fall_d = ~dout & prev_q;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               prev_q <= RST_VAL;
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               prev_q <= dout;
               rise_q <= rise_d;
               fall_q <= fall_d;
            end
         end

         assign rise = rise_q;
         assign fall = fall_q;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_reg_slave
//  Purpose  : SPI register-port slave, all four SPI modes, oversampled in the
//             clk domain. Frame = command word (MSB 1 = read, low ADDR_W bits
//             = start address) followed by burst data words with an
//             auto-incrementing address.
//  Ports    : clk, rst_n            - system clock, async active-low reset
//             ss, sclk, mosi        - asynchronous SPI pins from the master
//             miso, miso_oe         - SPI read data and its output enable
//             addr, wdata           - register address / write data
//             write_en, read_en     - one-cycle access strobes
//             rdata                 - read data, valid one clk after read_en
//             frame_done            - pulse when ss deasserts
//             frame_err             - sticky partial-word flag
//             busy                  - frame active
//  Revision : 1.0  initial release
// ============================================================================
module spi_reg_slave
   import spi_pkg::*;
#(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ss,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              write_en,
   output logic              read_en,
   input  logic [DATA_W-1:0] rdata,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam int CMD_RD_BIT  = cmd_rd_bit(DATA_W);
   localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic w_ss_rise, w_ss_fall, w_ss_lvl_unused;
   logic w_sclk_rise, w_sclk_fall, w_sclk_lvl_unused;
   logic w_mosi_s, w_mosi_rise_unused, w_mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGE_EN(1'b1)) u_ss_sync (
      .clk (clk), .rst_n (rst_n), .din (ss),
      .dout (w_ss_lvl_unused), .rise (w_ss_rise), .fall (w_ss_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL), .EDGE_EN(1'b1)) u_sclk_sync (
      .clk (clk), .rst_n (rst_n), .din (sclk),
      .dout (w_sclk_lvl_unused), .rise (w_sclk_rise), .fall (w_sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGE_EN(1'b0)) u_mosi_sync (
      .clk (clk), .rst_n (rst_n), .din (mosi),
      .dout (w_mosi_s), .rise (w_mosi_rise_unused), .fall (w_mosi_fall_unused)
   );

   logic w_sample, w_launch;
   assign w_sample = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
   assign w_launch = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   frame_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-2:0] rx_q, rx_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic              first_q, first_d;   // next launch edge presents MSB, no shift
   logic              load_q, load_d;     // rdata is valid this cycle
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              write_en_q, write_en_d;
   logic              read_en_q, read_en_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic              busy_q, busy_d;
   logic              miso_q, miso_d;

   logic [DATA_W-1:0] w_word;
   logic              w_last;

   assign w_word = {rx_q, w_mosi_s};
   assign w_last = (cnt_q == CNT_W'(DATA_W - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      first_d      = first_q;
      load_d       = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      write_en_d   = 1'b0;
      read_en_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;

      // Read pipeline: capture rdata the cycle after read_en, then advance.
      // A load and a launch edge never coincide given the SCLK phase minimum.
      load_d = read_en_q;
      if (load_q) begin
         tx_d    = rdata;
         first_d = 1'b1;
         addr_d  = addr_q + ADDR_W'(1);
      end else if (w_launch && (state_q == ST_RD)) begin
         // The MSB is already on miso after the load; the first launch edge
         // of a word only releases it, later ones shift.
         if (first_q) begin
            first_d = 1'b0;
         end else begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
         end
      end

      // Write address advances once its strobe has been presented
      if (write_en_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end

      // Bit sampling and word completion
      if ((state_q != ST_IDLE) && w_sample) begin
         rx_d = w_word[DATA_W-2:0];
         if (w_last) begin
            cnt_d = '0;
            case (state_q)
               ST_CMD: begin
                  addr_d = w_word[ADDR_W-1:0];
                  if (w_word[CMD_RD_BIT]) begin
                     state_d   = ST_RD;
                     read_en_d = 1'b1;
                  end else begin
                     state_d = ST_WR;
                  end
               end
               ST_WR: begin
                  wdata_d    = w_word;
                  write_en_d = 1'b1;
               end
               ST_RD: begin
                  read_en_d = 1'b1;
               end
               default: ;
            endcase
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Frame boundaries; a word completed in this same cycle is already
      // reflected in cnt_d, so it counts as whole.
      if (w_ss_rise) begin
         frame_done_d = 1'b1;
         if (cnt_d != '0) begin
            frame_err_d = 1'b1;
         end
         cnt_d   = '0;
         state_d = ST_IDLE;
         first_d = 1'b0;
      end else if (w_ss_fall) begin
         state_d     = ST_CMD;
         cnt_d       = '0;
         tx_d        = '0;
         first_d     = 1'b0;
         frame_err_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
      miso_d = (state_d == ST_RD) ? tx_d[DATA_W-1] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         first_q      <= 1'b0;
         load_q       <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         write_en_q   <= 1'b0;
         read_en_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         busy_q       <= 1'b0;
         miso_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         first_q      <= first_d;
         load_q       <= load_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         write_en_q   <= write_en_d;
         read_en_q    <= read_en_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         busy_q       <= busy_d;
         miso_q       <= miso_d;
      end
   end

   assign miso       = miso_q;
   assign miso_oe    = busy_q;
   assign busy       = busy_q;
   assign addr       = addr_q;
   assign wdata      = wdata_q;
   assign write_en   = write_en_q;
   assign read_en    = read_en_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_reg_slave
//  Purpose  : Directed self-checking bench; one slave instance per SPI mode
//             (index = {CPOL,CPHA}) sharing clk and rst_n.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_reg_slave;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       ss_p   [4];
   logic       sclk_p [4];
   logic       mosi_p [4];
   logic [7:0] rdata_r [4];

   logic       miso_w [4];
   logic       oe_w   [4];
   logic [4:0] addr_w [4];
   logic [7:0] wdata_w [4];
   logic       wen_w  [4];
   logic       ren_w  [4];
   logic       fd_w   [4];
   logic       err_w  [4];
   logic       busy_w [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dut
         spi_reg_slave #(
            .ADDR_W(5), .DATA_W(8),
            .CPOL(1'((gi >> 1) & 1)), .CPHA(1'(gi & 1)),
            .SYNC_STAGES(2)
         ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .ss         (ss_p[gi]),
            .sclk       (sclk_p[gi]),
            .mosi       (mosi_p[gi]),
            .miso       (miso_w[gi]),
            .miso_oe    (oe_w[gi]),
            .addr       (addr_w[gi]),
            .wdata      (wdata_w[gi]),
            .write_en   (wen_w[gi]),
            .read_en    (ren_w[gi]),
            .rdata      (rdata_r[gi]),
            .frame_done (fd_w[gi]),
            .frame_err  (err_w[gi]),
            .busy       (busy_w[gi])
         );
      end
   endgenerate

   // ------------------------------------------------------------------
   // Bus monitor and register-file model (rdata = addr ^ 0xFF, presented
   // one clk after read_en)
   // ------------------------------------------------------------------
   int         wr_n [4];
   int         rd_n [4];
   int         fd_n [4];
   int         both_n;
   logic [4:0] wr_a [4][32];
   logic [7:0] wr_d [4][32];
   logic [4:0] rd_a [4][32];
   logic       rd_pend [4];
   logic [4:0] pend_a  [4];

   initial begin
      both_n = 0;
      for (int m = 0; m < 4; m++) begin
         wr_n[m] = 0; rd_n[m] = 0; fd_n[m] = 0;
         rd_pend[m] = 1'b0; pend_a[m] = '0; rdata_r[m] = '0;
      end
   end

   always @(negedge clk) begin
      for (int m = 0; m < 4; m++) begin
         if (rd_pend[m]) rdata_r[m] = {3'b111, ~pend_a[m]};
         rd_pend[m] = ren_w[m];
         pend_a[m]  = addr_w[m];
         if (wen_w[m] && ren_w[m]) both_n++;
         if (wen_w[m] && wr_n[m] < 32) begin
            wr_a[m][wr_n[m]] = addr_w[m];
            wr_d[m][wr_n[m]] = wdata_w[m];
            wr_n[m]++;
         end
         if (ren_w[m] && rd_n[m] < 32) begin
            rd_a[m][rd_n[m]] = addr_w[m];
            rd_n[m]++;
         end
         if (fd_w[m]) fd_n[m]++;
      end
   end

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // SPI master
   // ------------------------------------------------------------------
   logic [7:0] cmd_rx;
   logic [7:0] rx_word [4];

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Shift nb bits of w (MSB first); r collects miso at each sample edge
   task automatic xfer_bits(input int m, input int hp, input logic [7:0] w,
                            input int nb, output logic [7:0] r);
      logic cpol, cpha;
      cpol = m[1];
      cpha = m[0];
      r    = '0;
      for (int b = 7; b > 7 - nb; b--) begin
         if (!cpha) begin
            mosi_p[m] = w[b];
            cyc(hp);
            sclk_p[m] = ~cpol;
            r[b]      = miso_w[m];
            cyc(hp);
            sclk_p[m] = cpol;
         end else begin
            sclk_p[m] = ~cpol;
            mosi_p[m] = w[b];
            cyc(hp);
            sclk_p[m] = cpol;
            r[b]      = miso_w[m];
            cyc(hp);
         end
      end
   endtask

   task automatic frame(input int m, input int hp, input logic [7:0] cmd,
                        input logic [31:0] data, input int nw, input int tail_bits);
      logic [7:0] r;
      ss_p[m] = 1'b0;
      cyc(hp);
      xfer_bits(m, hp, cmd, 8, cmd_rx);
      for (int k = 0; k < nw; k++) begin
         xfer_bits(m, hp, data[31 - 8*k -: 8], 8, r);
         rx_word[k] = r;
      end
      if (tail_bits > 0) xfer_bits(m, hp, 8'hFF, tail_bits, r);
      cyc(hp);
      ss_p[m]   = 1'b1;
      mosi_p[m] = 1'b0;
      cyc(20);
   endtask

   // Write start 3, data A5, 5A
   task automatic run_write(input int m, input int hp);
      int wb, fb, rb;
      wb = wr_n[m]; fb = fd_n[m]; rb = rd_n[m];
      frame(m, hp, 8'h03, 32'hA55A_0000, 2, 0);
      chk($sformatf("m%0d_wr_cnt", m), wr_n[m] - wb, 2);
      chk($sformatf("m%0d_wr0_addr", m), wr_a[m][wb], 5'd3);
      chk($sformatf("m%0d_wr0_data", m), wr_d[m][wb], 8'hA5);
      chk($sformatf("m%0d_wr1_addr", m), wr_a[m][wb+1], 5'd4);
      chk($sformatf("m%0d_wr1_data", m), wr_d[m][wb+1], 8'h5A);
      chk($sformatf("m%0d_wr_done", m), fd_n[m] - fb, 1);
      chk($sformatf("m%0d_wr_err", m), err_w[m], 0);
      chk($sformatf("m%0d_wr_no_rd", m), rd_n[m] - rb, 0);
   endtask

   // Read start 0x10: words 0xEF then 0xEE on miso
   task automatic run_read(input int m, input int hp);
      int wb, rb;
      wb = wr_n[m]; rb = rd_n[m];
      frame(m, hp, 8'h90, 32'h0, 2, 0);
      chk($sformatf("m%0d_rd_cmd_miso", m), cmd_rx, 8'h00);
      chk($sformatf("m%0d_rd_word0", m), rx_word[0], 8'hEF);
      chk($sformatf("m%0d_rd_word1", m), rx_word[1], 8'hEE);
      chk($sformatf("m%0d_rd_cnt_ge2", m), 32'(rd_n[m] - rb >= 2), 1);
      chk($sformatf("m%0d_rd0_addr", m), rd_a[m][rb], 5'h10);
      chk($sformatf("m%0d_rd1_addr", m), rd_a[m][rb+1], 5'h11);
      chk($sformatf("m%0d_rd_no_wr", m), wr_n[m] - wb, 0);
      chk($sformatf("m%0d_rd_err", m), err_w[m], 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      int wb, fb;
      rst_n = 1'b0;
      for (int m = 0; m < 4; m++) begin
         ss_p[m] = 1'b1; sclk_p[m] = m[1]; mosi_p[m] = 1'b0;
      end
      cyc(3);
      for (int m = 0; m < 4; m += 3) begin
         chk($sformatf("m%0d_reset_ctl", m),
             {miso_w[m], oe_w[m], wen_w[m], ren_w[m], fd_w[m], err_w[m], busy_w[m]}, 0);
         chk($sformatf("m%0d_reset_bus", m), {addr_w[m], wdata_w[m]}, 0);
      end
      rst_n = 1'b1;
      cyc(5);

      // Mode 0
      run_write(0, 8);
      run_read(0, 8);

      // Address wrap 31 -> 0 -> 1
      wb = wr_n[0];
      frame(0, 8, 8'h1F, 32'h1122_3300, 3, 0);
      chk("wrap_cnt", wr_n[0] - wb, 3);
      chk("wrap_a0", wr_a[0][wb], 5'd31);
      chk("wrap_a1", wr_a[0][wb+1], 5'd0);
      chk("wrap_a2", wr_a[0][wb+2], 5'd1);
      chk("wrap_d2", wr_d[0][wb+2], 8'h33);

      // Mode 3 read, then modes 1 and 2 at the minimum SCLK phase
      run_read(3, 8);
      run_write(1, 5);
      run_read(1, 5);
      run_write(2, 5);
      run_read(2, 5);

      // Partial word: command + 4 bits
      wb = wr_n[0]; fb = fd_n[0];
      frame(0, 8, 8'h05, 32'h0, 0, 4);
      chk("partial_no_wr", wr_n[0] - wb, 0);
      chk("partial_err", err_w[0], 1);
      chk("partial_done", fd_n[0] - fb, 1);

      // Next frame start clears the error and the frame decodes normally
      wb = wr_n[0];
      fork
         frame(0, 8, 8'h07, 32'h3C00_0000, 1, 0);
         begin
            cyc(7);
            chk("err_cleared", err_w[0], 0);
            chk("busy_in_frame", busy_w[0], 1);
            chk("oe_in_frame", oe_w[0], 1);
         end
      join
      chk("after_err_addr", wr_a[0][wb], 5'd7);
      chk("after_err_data", wr_d[0][wb], 8'h3C);

      // Reset in the middle of a write frame
      ss_p[0] = 1'b0;
      cyc(8);
      xfer_bits(0, 8, 8'h02, 8, r);
      xfer_bits(0, 8, 8'h55, 3, r);
      chk("pre_rst_busy", busy_w[0], 1);
      chk("pre_rst_addr", addr_w[0], 5'd2);
      rst_n = 1'b0;
      #1;
      chk("rst_ctl", {miso_w[0], oe_w[0], wen_w[0], ren_w[0], fd_w[0], err_w[0], busy_w[0]}, 0);
      chk("rst_bus", {addr_w[0], wdata_w[0]}, 0);
      ss_p[0] = 1'b1; sclk_p[0] = 1'b0; mosi_p[0] = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(10);
      wb = wr_n[0];
      frame(0, 8, 8'h08, 32'h7700_0000, 1, 0);
      chk("post_rst_cnt", wr_n[0] - wb, 1);
      chk("post_rst_addr", wr_a[0][wb], 5'd8);
      chk("post_rst_data", wr_d[0][wb], 8'h77);
      chk("post_rst_err", err_w[0], 0);

      chk("never_both_strobes", both_n, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spi_reg_slave.md
# spi_reg_slave

Parametrised SPI register-port slave: the next generation of the SID-register SPI receiver. It adds all four SPI modes, configurable address/data widths, burst transfers with auto-incrementing address, register readback on MISO, and frame-error detection. It sits between the external SPI master and the register file / sound-core RAM, in the `clk` domain, with SPI inputs oversampled.

## Interface
- `ADDR_W`, 5: register address width; must be ≤ `DATA_W`-1.
- `DATA_W`, 8: word width; command and data words are both `DATA_W` bits, MSB first.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
- `SYNC_STAGES`, 2: synchroniser depth on `ss`, `sclk` and `mosi`; ≥2.

Ports:
- `clk`  in  1  system clock; only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ss`  in  1  slave select, active low, asynchronous.
- `sclk`  in  1  SPI clock, asynchronous.
- `mosi`  in  1  SPI data in.
- `miso`  out  1  SPI data out.
- `miso_oe`  out  1  high while the frame is active.
- `addr`  out  ADDR_W  register address for write or read.
- `wdata`  out  DATA_W  write data.
- `write_en`  out  1  one-cycle write strobe.
- `read_en`  out  1  one-cycle read request.
- `rdata`  in  DATA_W  read data; valid exactly one `clk` after `read_en`.
- `frame_done`  out  1  one-cycle pulse when `ss` deasserts.
- `frame_err`  out  1  sticky flag, set by a partial word; cleared at next frame start.
- `busy`  out  1  frame active (synchronised `ss` low).

## Operation
- Sample edge is rising when `CPOL`==`CPHA`, otherwise falling. The launch edge is the opposite edge. Both are detected from synchronised `sclk`.
- Frame layout: command word, then N ≥ 0 data words.
  - Command MSB: 1 = read, 0 = write.
  - Command bits [ADDR_W-1:0]: start address.
  - Remaining bits are ignored.
- Frame FSM states:
  - IDLE → CMD on `ss` falling.
  - CMD → WR or RD after `DATA_W` sampled bits.
  - WR/RD → IDLE on `ss` rising.
  - Any state → IDLE on `ss` rising.
- WR:
  - Each completed word drives `addr`=current address, `wdata`=word, and a `write_en` pulse.
  - Address then increments modulo 2^ADDR_W: wrap 31→0 at default.
- RD:
  - On command completion, and on each completed data word, pulse `read_en` with `addr`=current address.
  - Latch `rdata` into the TX shift register one cycle later, then increment the address.
  - Each launch edge shifts the TX register out MSB first. `miso` = TX MSB.
  - Data words received on `mosi` during RD are ignored.
- `miso` is 0 during CMD and outside frames. `miso_oe` = `busy`.
- On `ss` rising:
  - Pulse `frame_done`.
  - If the bit counter is nonzero (partial word), set `frame_err` and suppress any strobe for that partial word.
  - Reset the bit counter and FSM.
- `ss` rising and the last sample edge in the same `clk` cycle: the word is completed and strobed first; the frame then ends with no error.

## Timing
- Reset values: `miso`, `miso_oe`, `write_en`, `read_en`, `frame_done`, `frame_err`, `busy` = 0; `addr`, `wdata` = 0; FSM = IDLE; counters = 0.
- Input latency: `SYNC_STAGES`+1 `clk` from a pin edge to its detected edge.
- Strobe latency:
  - `write_en` asserts on the `clk` after the detected last sample edge.
  - `read_en` asserts at the same point; `rdata` is captured one cycle later.
- SCLK constraint: each SCLK phase must last ≥ `SYNC_STAGES`+3 `clk` cycles. This guarantees TX load precedes the next launch edge.
- `ss` setup: first SCLK edge ≥ `SYNC_STAGES`+2 `clk` after `ss` falls.
- `write_en`/`read_en` are never asserted together. The consumer needs no back-pressure: one access per word.

## Structure
- Shared package `spi_pkg`:
  - Frame FSM state enum (IDLE, CMD, WR, RD).
  - Command-bit position constant `CMD_RD_BIT = DATA_W-1`.
  - Sample/launch-edge selection function of `CPOL`/`CPHA`.
- Sub-module `spi_sync_edge`: `SYNC_STAGES` synchroniser plus rise/fall detect. Instantiated for `ss` and `sclk`; `mosi` uses the same sync without edge outputs.

## Test plan
- Mode 0, write `0x03` start, data `0xA5,0x5A` → `write_en` pulses with (addr 3, `0xA5`), then (4, `0x5A`); `frame_done` once; `frame_err`=0.
- Write start 31, three words → addresses 31, 0, 1 (wrap).
- Mode 3, read start `0x10` with `rdata` = addr XOR `0xFF` → `miso` shifts `0xEF`, then `0xEE`, MSB first; `read_en` pulses at 16 then 17; `write_en` never asserts.
- Repeat the write and read cases for modes 1 and 2 at the minimum SCLK phase (`SYNC_STAGES`+3) → identical register traffic.
- `ss` raised after 12 bits (command + 4 bits) → no strobe for the partial word; `frame_err`=1; next `ss` fall clears it.
- Assert `rst_n`=0 mid-frame → all outputs return to reset values immediately; after release, the next frame decodes normally.
